// File: rtl/iir_chan_scheduler.sv
// Round-robin scheduler sharing one IIR filter datapath between NCH sample requesters.
// Holds a coefficient per channel, sequences each job through the filter and returns a channel-tagged result.
module iir_chan_scheduler #(
   parameter int W        = 4,
   parameter int NCH      = 4,
   parameter int FLT_LAT  = 1,
   parameter int COEF_RST = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [$clog2(NCH)-1:0]   cfg_ch,
   input  logic [W-1:0]             cfg_coef,
   input  logic [NCH-1:0]           req_valid,
   input  logic [NCH*W-1:0]         req_data,
   output logic [NCH-1:0]           req_ready,
   output logic [W-1:0]             flt_a,
   output logic [W-1:0]             flt_x,
   output logic                     flt_en,
   input  logic [W-1:0]             flt_y,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [$clog2(NCH)-1:0]   res_ch,
   output logic [W-1:0]             res_data,
   output logic                     busy
);

   localparam int CW = $clog2(NCH);
   localparam int LW = (FLT_LAT < 2) ? 1 : $clog2(FLT_LAT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t          state_reg;
   logic [W-1:0]    coef_reg [NCH];
   logic [W-1:0]    sample [NCH];
   logic [CW-1:0]   last_grant_reg;
   logic [LW-1:0]   cnt_reg;
   logic [W-1:0]    flt_a_reg;
   logic [W-1:0]    flt_x_reg;
   logic            flt_en_reg;
   logic [W-1:0]    res_data_reg;
   logic [CW-1:0]   res_ch_reg;
   logic            res_valid_reg;
   logic            busy_reg;

   logic [CW-1:0]   win_idx;
   logic [CW-1:0]   scan_idx;
   logic            win_found;
   logic            hs;

   // Per-channel sample unpacking and coefficient registers; out-of-range cfg_ch never matches.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         assign sample[gi]    = req_data[gi*W +: W];
         assign req_ready[gi] = hs && (win_idx == CW'(gi));

         always_ff @(posedge clk) begin
            if (rst) begin
               coef_reg[gi] <= W'(COEF_RST);
            end else if (cfg_we && (cfg_ch == CW'(gi))) begin
               coef_reg[gi] <= cfg_coef;
            end
         end
      end
   endgenerate

   // Search starts one past the previous winner so every channel gets a fair turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 1; k <= NCH; k++) begin
         scan_idx = CW'((int'(last_grant_reg) + k) % NCH);
         if (!win_found && req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign hs = (state_reg == IDLE) && win_found;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= CW'(NCH - 1);
         cnt_reg        <= '0;
         flt_a_reg      <= '0;
         flt_x_reg      <= '0;
         flt_en_reg     <= 1'b0;
         res_data_reg   <= '0;
         res_ch_reg     <= '0;
         res_valid_reg  <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         flt_en_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (hs) begin
                  flt_x_reg      <= sample[win_idx];
                  flt_a_reg      <= coef_reg[win_idx];
                  res_ch_reg     <= win_idx;
                  last_grant_reg <= win_idx;
                  cnt_reg        <= LW'(FLT_LAT);
                  flt_en_reg     <= 1'b1;
                  busy_reg       <= 1'b1;
                  state_reg      <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_reg == '0) begin
                  res_data_reg  <= flt_y;
                  res_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else begin
                  cnt_reg <= cnt_reg - LW'(1);
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign flt_a     = flt_a_reg;
   assign flt_x     = flt_x_reg;
   assign flt_en    = flt_en_reg;
   assign res_data  = res_data_reg;
   assign res_ch    = res_ch_reg;
   assign res_valid = res_valid_reg;
   assign busy      = busy_reg;

endmodule
